// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its neighbours (ID, EX, loader).
// The stage uses the slave modport; whatever drives it uses master.
interface if_stage_if #(
  parameter int unsigned IMEM_DEPTH = 256
) ();
  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic          i_enable;
  logic          i_stall;
  logic          i_branch_prediction;
  logic [31:0]   i_branch_target_addr;
  logic          i_mispredict;
  logic [31:0]   i_recovery_addr;
  logic          i_imem_write_en;
  logic [AW-1:0] i_imem_addr;
  logic [31:0]   i_imem_data;
  logic [31:0]   o_pc;
  logic [31:0]   o_next_pc;
  logic [31:0]   o_instruction;
  logic          o_valid;
  logic          o_halt;

  modport master (
    output i_enable, i_stall, i_branch_prediction, i_branch_target_addr,
           i_mispredict, i_recovery_addr, i_imem_write_en, i_imem_addr, i_imem_data,
    input  o_pc, o_next_pc, o_instruction, o_valid, o_halt
  );

  modport slave (
    input  i_enable, i_stall, i_branch_prediction, i_branch_target_addr,
           i_mispredict, i_recovery_addr, i_imem_write_en, i_imem_addr, i_imem_data,
    output o_pc, o_next_pc, o_instruction, o_valid, o_halt
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, runtime-loadable word-addressed imem,
// and the IF/ID register, with stall, predicted redirect, recovery and halt.
module if_stage #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input logic       clk,
  input logic       reset,
  if_stage_if.slave bus
);
  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    IFID_LOAD,
    IFID_HOLD,
    IFID_BUBBLE
  } ifid_op_t;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_word;
  logic [31:0] ifid_next_pc;
  logic [31:0] ifid_instruction;
  logic        ifid_valid;
  logic        halted;
  logic        halted_next;
  logic        hold;
  ifid_op_t    ifid_op;

  // No reset on the array: program contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (bus.i_imem_write_en) imem[bus.i_imem_addr] <= bus.i_imem_data;
  end

  assign pc_plus4   = pc + 32'd4;
  assign fetch_word = imem[pc[AW+1:2]];
  assign hold       = !bus.i_enable || bus.i_stall;

  // Halted ranks above the predicted redirect for PC; both bubble IF/ID,
  // so one shared ordering serves PC and IF/ID alike.
  always_comb begin
    pc_next     = pc_plus4;
    ifid_op     = IFID_LOAD;
    halted_next = halted;
    if (bus.i_mispredict) begin
      pc_next     = bus.i_recovery_addr;
      ifid_op     = IFID_BUBBLE;
      halted_next = 1'b0;
    end else if (hold) begin
      pc_next = pc;
      ifid_op = IFID_HOLD;
    end else if (halted) begin
      pc_next = pc;
      ifid_op = IFID_BUBBLE;
    end else if (bus.i_branch_prediction) begin
      pc_next = bus.i_branch_target_addr;
      ifid_op = IFID_BUBBLE;
    end else if (fetch_word == HALT_WORD) begin
      halted_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc               <= '0;
      halted           <= 1'b0;
      ifid_next_pc     <= '0;
      ifid_instruction <= '0;
      ifid_valid       <= 1'b0;
    end else begin
      pc     <= pc_next;
      halted <= halted_next;
      case (ifid_op)
        IFID_LOAD: begin
          ifid_next_pc     <= pc_plus4;
          ifid_instruction <= fetch_word;
          ifid_valid       <= 1'b1;
        end
        IFID_BUBBLE: begin
          ifid_next_pc     <= '0;
          ifid_instruction <= '0;
          ifid_valid       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_pc          = pc;
  assign bus.o_next_pc     = ifid_next_pc;
  assign bus.o_instruction = ifid_instruction;
  assign bus.o_valid       = ifid_valid;
  assign bus.o_halt        = halted;
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter, a word-addressed instruction memory loadable at runtime, and the IF/ID pipeline register whose outputs drive decode's `i_next_pc` and `i_instruction`. Handles stalls, predicted-taken redirects from ID, misprediction recovery from EX, and a halt word that freezes fetch.

## Interface
- `IMEM_DEPTH`, 256: instruction memory depth in 32-bit words; power of two. `AW = log2(IMEM_DEPTH)`.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction word that halts fetch.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `i_enable`  in  1: global run enable; 0 holds PC and IF/ID.
- `i_stall`  in  1: hazard stall from ID; holds PC and IF/ID.
- `i_branch_prediction`  in  1: ID predicts taken this cycle.
- `i_branch_target_addr`  in  32: ID-computed target.
- `i_mispredict`  in  1: EX resolved a misprediction.
- `i_recovery_addr`  in  32: correct PC from EX.
- `i_imem_write_en`  in  1: loader write strobe.
- `i_imem_addr`  in  AW: loader word address.
- `i_imem_data`  in  32: loader write data.
- `o_pc`  out  32: current PC register.
- `o_next_pc`  out  32: IF/ID PC+4 of the latched instruction.
- `o_instruction`  out  32: IF/ID instruction.
- `o_valid`  out  1: IF/ID holds a real instruction.
- `o_halt`  out  1: fetch halted.

## Operation
- Memory: array of `IMEM_DEPTH` words, asynchronous read at index `pc[AW+1:2]`. `pc[1:0]` is ignored. Upper PC bits are ignored, so addresses wrap modulo depth. Synchronous write on `i_imem_write_en`. Contents are not cleared by reset.
- `pc_plus4 = pc + 4`, 32-bit modular, so 0xFFFF_FFFC becomes 0.
- Internal `halted` flag drives `o_halt`.
- Next PC is selected in priority order:
  1. `i_mispredict`: `i_recovery_addr`.
  2. `!i_enable` or `i_stall` or `halted`: hold.
  3. `i_branch_prediction`: `i_branch_target_addr`.
  4. Otherwise: `pc_plus4`.
- IF/ID update is selected in the same priority order:
  1. `i_mispredict`: bubble.
  2. `!i_enable` or `i_stall`: hold.
  3. `i_branch_prediction`: bubble, because the word at `pc` is wrong-path.
  4. `halted`: bubble.
  5. Otherwise: load `{pc_plus4, imem[pc], 1}`.
- A bubble sets `o_instruction` = 0 (NOP), `o_next_pc` = 0, and `o_valid` = 0.
- Halt behaviour:
  - When rule 5 loads a word equal to `HALT_WORD`, that word is latched with valid = 1 and `halted` sets on the same edge.
  - A halted PC holds.
  - `i_mispredict` clears `halted` (the halt was wrong-path) and redirects.
  - Only reset or a mispredict clears `halted`.
- A loader write to the address being fetched on the same cycle: the fetch returns the old word; the new word is visible the following cycle.

## Timing
- Reset (`reset` = 0, asynchronous): `o_pc` = 0, `o_next_pc` = 0, `o_instruction` = 0, `o_valid` = 0, `o_halt` = 0. The first fetch from address 0 latches on the first rising edge after `reset` deasserts.
- Latency: the instruction at PC appears on IF/ID outputs one cycle after PC presents it. Steady state is 1 instruction per cycle.
- Predicted-taken costs 1 bubble. A mispredict costs a bubble on the edge it is seen; the recovery-address fetch latches on the next edge.
- Simultaneous events:
  - `i_mispredict` together with `i_stall` or `i_branch_prediction`: mispredict wins.
  - `i_stall` together with `i_branch_prediction`: stall wins. The redirect is taken when the stall drops and ID still asserts it.
- Reset mid-stall or mid-halt returns all state to reset values immediately.

## Test plan
- Reset/sequential fetch: preload words 0..3 = 0x2001_0005, 0x2002_0007, 0x0022_1820, 0xAC03_0000, then release reset. Required: IF/ID shows them on cycles 1-4 with `o_next_pc` = 4, 8, 12, 16, and `o_valid` = 1.
- Stall: assert `i_stall` for 2 cycles while IF/ID holds PC 8. Required: `o_pc` stays 12, IF/ID is unchanged, and fetch resumes at word 3 afterwards.
- Predicted branch: at `o_pc` = 0x10, pulse `i_branch_prediction` with target 0x40. Required: next IF/ID is a bubble (`o_valid` = 0), `o_pc` = 0x40, and the following IF/ID shows word 16 with `o_next_pc` = 0x44.
- Mispredict priority: in one cycle assert `i_mispredict` (recovery 0x20), `i_stall`, and `i_branch_prediction` (target 0x80). Required: IF/ID is a bubble, `o_pc` = 0x20, and word 8 is latched on the next edge.
- Halt/recovery:
  - Word 5 = 0xFFFF_FFFF. Required: latched with valid, `o_halt` = 1, PC frozen at 0x18, and bubbles thereafter.
  - Then pulse `i_mispredict` with recovery 0x0. Required: `o_halt` = 0 and fetch restarts at 0.
- Wrap/loader:
  - With `IMEM_DEPTH` = 256, write word 0 = 0x1234_5678, then redirect to 0x400. Required: fetches 0x1234_5678.
  - Recovery to 0xFFFF_FFFC. Required: next `o_pc` = 0.
  - Same-cycle write/read. Required: returns the old word.
